// File: rtl/conv_pool_layer.sv
// conv_pool_layer: streaming KxK valid convolution followed by PxP max pooling over the conv map
// Ports: clk, reset (async, active-low); pxl_in/i_data_valid raster pixel input;
// i_kernel_data KxK signed 16-bit weights, (i,j) at bits [16(iK+j) +: 16];
// pxl_out/o_data_valid conv stream with count of conv outputs in this frame;
// o_max_pooled_pixel/o_data_valid_pooling pooled stream.
module conv_pool_layer #(
  parameter int N = 6,
  parameter int M = 6,
  parameter int K = 3,
  parameter int K_stride = 1,
  parameter int P = 2,
  parameter int P_stride = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pxl_in,
  input  logic              i_data_valid,
  input  logic [16*K*K-1:0] i_kernel_data,
  output logic [15:0]       pxl_out,
  output logic [9:0]        count,
  output logic              o_data_valid,
  output logic [15:0]       o_max_pooled_pixel,
  output logic              o_data_valid_pooling
);
  localparam int W   = (N - K) / K_stride + 1;
  localparam int H   = (M - K) / K_stride + 1;
  localparam int CW  = $clog2(N + 1);
  localparam int RW  = $clog2(M + 1);
  localparam int PCW = $clog2(W + 1);
  localparam int PRW = $clog2(H + 1);
  logic [CW-1:0]     c;
  logic [RW-1:0]     r;
  logic signed [15:0] lb [K-1][N];
  logic signed [15:0] win [K][K];
  logic signed [15:0] wt [K][K];
  logic signed [15:0] col [K];
  logic signed [15:0] wn [K][K];
  logic signed [15:0] acc;
  logic              fire, last_c, last_r;
  logic [PCW-1:0]    pc;
  logic [PRW-1:0]    pr;
  logic signed [15:0] plb [P-1][W];
  logic signed [15:0] pwin [P][P];
  logic signed [15:0] pcol [P];
  logic signed [15:0] pwn [P][P];
  logic signed [15:0] mx;
  logic              pfire, plast_c, plast_r;
  // lb[0] holds the oldest buffered row; the window's newest column is j=K-1.
  // Only the low 16 bits of the wide sum reach pxl_out, and those depend only on
  // the low 16 bits of each product, so the sum is formed modulo 2^16.
  always_comb begin
    for (int i = 0; i < K - 1; i++) col[i] = lb[i][c];
    col[K-1] = pxl_in;
    acc = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) wn[i][j] = win[i][j+1];
      wn[i][K-1] = col[i];
      for (int j = 0; j < K; j++) begin
        wt[i][j] = i_kernel_data[16*(i*K+j) +: 16];
        acc = acc + wn[i][j] * wt[i][j];
      end
    end
    last_c = int'(c) == N - 1;
    last_r = int'(r) == M - 1;
    fire = i_data_valid && int'(r) >= K - 1 && int'(c) >= K - 1 &&
           (int'(r) - (K - 1)) % K_stride == 0 && (int'(c) - (K - 1)) % K_stride == 0;
  end
  always_comb begin
    for (int i = 0; i < P - 1; i++) pcol[i] = plb[i][pc];
    pcol[P-1] = pxl_out;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P - 1; j++) pwn[i][j] = pwin[i][j+1];
      pwn[i][P-1] = pcol[i];
    end
    mx = pwn[0][0];
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P; j++)
        mx = pwn[i][j] > mx ? pwn[i][j] : mx;
    plast_c = int'(pc) == W - 1;
    plast_r = int'(pr) == H - 1;
    pfire = o_data_valid && int'(pr) >= P - 1 && int'(pc) >= P - 1 &&
            (int'(pr) - (P - 1)) % P_stride == 0 && (int'(pc) - (P - 1)) % P_stride == 0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c            <= '0;
      r            <= '0;
      count        <= '0;
      pxl_out      <= '0;
      o_data_valid <= 1'b0;
      lb           <= '{default: '0};
      win          <= '{default: '0};
    end else begin
      o_data_valid <= fire;
      if (fire) pxl_out <= acc;
      if (i_data_valid) begin
        c     <= last_c ? '0 : c + 1'b1;
        r     <= last_c ? (last_r ? '0 : r + 1'b1) : r;
        count <= (r == '0 && c == '0 ? 10'd0 : count) + 10'(fire);
        for (int i = 0; i < K - 1; i++) lb[i][c] <= col[i+1];
        win   <= wn;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc                   <= '0;
      pr                   <= '0;
      o_max_pooled_pixel   <= '0;
      o_data_valid_pooling <= 1'b0;
      plb                  <= '{default: '0};
      pwin                 <= '{default: '0};
    end else begin
      o_data_valid_pooling <= pfire;
      if (pfire) o_max_pooled_pixel <= mx;
      if (o_data_valid) begin
        pc   <= plast_c ? '0 : pc + 1'b1;
        pr   <= plast_c ? (plast_r ? '0 : pr + 1'b1) : pr;
        for (int i = 0; i < P - 1; i++) plb[i][pc] <= pcol[i+1];
        pwin <= pwn;
      end
    end
  end
endmodule

// File: tb/tb_conv_pool_layer.sv
// tb_conv_pool_layer: scoreboard bench for conv_pool_layer
module tb_conv_pool_layer;
  localparam int N = 6, M = 6, K = 3, KS = 1, P = 2, PS = 2;
  localparam int W = (N - K) / KS + 1, H = (M - K) / KS + 1;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_data_valid = 1'b0;
  logic [15:0]       pxl_in = '0;
  logic [16*K*K-1:0] i_kernel_data = '0;
  logic [15:0]       pxl_out, o_max_pooled_pixel;
  logic [9:0]        count;
  logic              o_data_valid, o_data_valid_pooling;
  typedef struct {
    logic [15:0] v;
    int          cyc;
    int          cnt;
  } exp_t;
  exp_t    cq[$], pq[$];
  int      cyc = 0, passed = 0, total = 0, ccount = 0;
  shortint kw [K][K];
  shortint img [M][N];
  shortint cm [H][W];
  logic [15:0] last_conv = '0, last_pool = '0;
  conv_pool_layer #(.N(N), .M(M), .K(K), .K_stride(KS), .P(P), .P_stride(PS)) dut (
    .clk(clk), .reset(reset), .pxl_in(pxl_in), .i_data_valid(i_data_valid),
    .i_kernel_data(i_kernel_data), .pxl_out(pxl_out), .count(count),
    .o_data_valid(o_data_valid), .o_max_pooled_pixel(o_max_pooled_pixel),
    .o_data_valid_pooling(o_data_valid_pooling)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic set_kernel(input shortint w);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        kw[i][j] = w;
        i_kernel_data[16*(i*K+j) +: 16] = w;
      end
  endtask
  task automatic step(input logic v, input logic [15:0] px);
    exp_t e;
    i_data_valid = v;
    pxl_in = px;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (o_data_valid) begin
      last_conv = pxl_out;
      total++;
      if (cq.size() == 0) $display("FAIL conv_extra: pulse at cycle %0d value %h, required no pulse", cyc, pxl_out);
      else begin
        passed++;
        e = cq.pop_front();
        total += 3;
        if (pxl_out !== e.v) $display("FAIL conv_value: got %h, required %h", pxl_out, e.v); else passed++;
        if (cyc !== e.cyc) $display("FAIL conv_timing: pulse at cycle %0d, required %0d", cyc, e.cyc); else passed++;
        if (count !== 10'(e.cnt)) $display("FAIL conv_count: got %0d, required %0d", count, e.cnt); else passed++;
      end
    end else if (cq.size() != 0 && cq[0].cyc <= cyc) begin
      total++;
      $display("FAIL conv_missing: no pulse at cycle %0d, required value %h", cyc, cq[0].v);
      void'(cq.pop_front());
    end
    if (o_data_valid_pooling) begin
      last_pool = o_max_pooled_pixel;
      total++;
      if (pq.size() == 0) $display("FAIL pool_extra: pulse at cycle %0d value %h, required no pulse", cyc, o_max_pooled_pixel);
      else begin
        passed++;
        e = pq.pop_front();
        total += 2;
        if (o_max_pooled_pixel !== e.v) $display("FAIL pool_value: got %h, required %h", o_max_pooled_pixel, e.v); else passed++;
        if (cyc !== e.cyc) $display("FAIL pool_timing: pulse at cycle %0d, required %0d", cyc, e.cyc); else passed++;
      end
    end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
      total++;
      $display("FAIL pool_missing: no pulse at cycle %0d, required value %h", cyc, pq[0].v);
      void'(pq.pop_front());
    end
  endtask
  task automatic drive_frame(input int first, input int last, input int ga, input int gla,
                             input int gb, input int glb, input bit sat);
    for (int idx = first; idx <= last; idx++) begin
      int      r = idx / N;
      int      c = idx % N;
      int      cr, cc;
      shortint x = sat ? 16'h7FFF : shortint'(6 * r + c);
      longint  s;
      shortint m;
      img[r][c] = x;
      if (idx == 0) ccount = 0;
      if (r >= K - 1 && c >= K - 1 && (r - K + 1) % KS == 0 && (c - K + 1) % KS == 0) begin
        cr = (r - K + 1) / KS;
        cc = (c - K + 1) / KS;
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += longint'(kw[i][j]) * longint'(img[r-K+1+i][c-K+1+j]);
        cm[cr][cc] = shortint'(s[15:0]);
        ccount++;
        cq.push_back('{s[15:0], cyc + 1, ccount});
        if (cr >= P - 1 && cc >= P - 1 && (cr - P + 1) % PS == 0 && (cc - P + 1) % PS == 0) begin
          m = cm[cr-P+1][cc-P+1];
          for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++)
              if (cm[cr-P+1+i][cc-P+1+j] > m) m = cm[cr-P+1+i][cc-P+1+j];
          pq.push_back('{16'(m), cyc + 2, 0});
        end
      end
      step(1'b1, x);
      if (idx == ga) repeat (gla) step(1'b0, 16'hDEAD);
      if (idx == gb) repeat (glb) step(1'b0, 16'hBEEF);
    end
  endtask
  task automatic drain();
    repeat (4) step(1'b0, 16'h0);
  endtask
  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++;
    if ({pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling} !== '0)
      $display("FAIL reset_outputs: got %h/%0d/%b/%h/%b, required all zero",
               pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    drain();
  endtask
  task automatic test_conv_ones();
    set_kernel(16'sd1);
    drive_frame(0, N * M - 1, -1, 0, -1, 0, 1'b0);
    drain();
    total += 4;
    if (cq.size() + pq.size() != 0) $display("FAIL ones_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (count !== 10'd16) $display("FAIL ones_count: got %0d, required 16", count); else passed++;
    if (last_conv !== 16'd252) $display("FAIL ones_last_conv: got %0d, required 252", last_conv); else passed++;
    if (last_pool !== 16'd252) $display("FAIL ones_last_pool: got %0d, required 252", last_pool); else passed++;
  endtask
  task automatic test_conv_neg();
    set_kernel(-16'sd1);
    drive_frame(0, N * M - 1, -1, 0, -1, 0, 1'b0);
    drain();
    total += 3;
    if (cq.size() + pq.size() != 0) $display("FAIL neg_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (last_conv !== 16'hFF04) $display("FAIL neg_last_conv: got %h, required ff04", last_conv); else passed++;
    if (last_pool !== 16'hFF43) $display("FAIL neg_last_pool: got %h, required ff43", last_pool); else passed++;
  endtask
  task automatic test_gaps();
    set_kernel(16'sd1);
    drive_frame(0, N * M - 1, 8, 3, 20, 1, 1'b0);
    drain();
    total += 2;
    if (cq.size() + pq.size() != 0) $display("FAIL gaps_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (count !== 10'd16) $display("FAIL gaps_count: got %0d, required 16", count); else passed++;
  endtask
  task automatic test_back_to_back();
    set_kernel(16'sd1);
    drive_frame(0, N * M - 1, -1, 0, -1, 0, 1'b0);
    total++;
    if (count !== 10'd16) $display("FAIL b2b_count_end: got %0d, required 16", count); else passed++;
    drive_frame(0, 0, -1, 0, -1, 0, 1'b0);
    total++;
    if (count !== 10'd0) $display("FAIL b2b_count_clear: got %0d, required 0", count); else passed++;
    drive_frame(1, N * M - 1, -1, 0, -1, 0, 1'b0);
    drain();
    total += 3;
    if (cq.size() + pq.size() != 0) $display("FAIL b2b_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (count !== 10'd16) $display("FAIL b2b_count: got %0d, required 16", count); else passed++;
    if (last_pool !== 16'd252) $display("FAIL b2b_last_pool: got %0d, required 252", last_pool); else passed++;
  endtask
  task automatic test_reset_mid_frame();
    set_kernel(16'sd1);
    drive_frame(0, 17, -1, 0, -1, 0, 1'b0);
    reset = 1'b0;
    #1;
    total++;
    if ({pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling} !== '0)
      $display("FAIL midreset_outputs: got %h/%0d/%b/%h/%b, required all zero",
               pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    total++;
    if ({pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling} !== '0)
      $display("FAIL midreset_held: got %h/%0d/%b/%h/%b, required all zero",
               pxl_out, count, o_data_valid, o_max_pooled_pixel, o_data_valid_pooling);
    else passed++;
    reset = 1'b1;
    cq.delete();
    pq.delete();
    drain();
    drive_frame(0, N * M - 1, -1, 0, -1, 0, 1'b0);
    drain();
    total += 3;
    if (cq.size() + pq.size() != 0) $display("FAIL midreset_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (count !== 10'd16) $display("FAIL midreset_count: got %0d, required 16", count); else passed++;
    if (last_pool !== 16'd252) $display("FAIL midreset_last_pool: got %0d, required 252", last_pool); else passed++;
  endtask
  task automatic test_overflow();
    set_kernel(16'sd1);
    drive_frame(0, N * M - 1, -1, 0, -1, 0, 1'b1);
    drain();
    total += 3;
    if (cq.size() + pq.size() != 0) $display("FAIL ovf_drained: %0d left, required 0", cq.size() + pq.size()); else passed++;
    if (last_conv !== 16'h7FF7) $display("FAIL ovf_conv: got %h, required 7ff7", last_conv); else passed++;
    if (last_pool !== 16'h7FF7) $display("FAIL ovf_pool: got %h, required 7ff7", last_pool); else passed++;
  endtask
  initial begin
    test_reset();
    test_conv_ones();
    test_conv_neg();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_overflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_pool_layer.md
Name: conv_pool_layer

Overview:
- Streaming CNN layer: 2-D valid convolution (KxK signed kernel, stride K_stride) over an M-row x N-column image, followed by PxP max pooling (stride P_stride).
- Input is one 16-bit pixel per accepted cycle in raster order.
- Exposes both the raw convolution stream and the pooled stream.
- Sits between the pixel source (or the previous layer) and the next layer.

Parameters:
- N, 6: image columns.
- M, 6: image rows.
- K, 3: convolution kernel size.
- K_stride, 1: convolution stride (rows and columns).
- P, 2: pooling window size.
- P_stride, 2: pooling stride.
- Derived: W=(N-K)/K_stride+1 and H=(M-K)/K_stride+1 give the conv map size. PW=(W-P)/P_stride+1 and PH=(H-P)/P_stride+1 give the pooled map size. Integer division throughout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pxl_in  in  16  input pixel, signed two's complement.
- i_data_valid  in  1  pxl_in is accepted on this edge.
- i_kernel_data  in  16*K*K  signed weights; weight (row i, col j) sits at bits [16(iK+j)+15 : 16(iK+j)]. Must be held stable during a frame.
- pxl_out  out  16  convolution result.
- count  out  10  convolution outputs emitted in the current frame.
- o_data_valid  out  1  pxl_out valid, one-cycle pulse.
- o_max_pooled_pixel  out  16  pooled result.
- o_data_valid_pooling  out  1  o_max_pooled_pixel valid, one-cycle pulse.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, row/col counters 0, line buffers and pooling buffers cleared. The partial frame is discarded; the next accepted pixel is pixel (0,0).
- Accept: pixel taken only on edges with i_data_valid=1. When i_data_valid=0, all state holds, so gaps of any length are transparent.
- Position tracking: column counter c counts 0..N-1, row counter r counts 0..M-1. After pixel (M-1,N-1) both wrap to 0 and the next frame starts immediately.
- Conv storage: K-1 line buffers of N pixels plus a KxK window register.
- Conv output condition: pixel (r,c) accepted with r>=K-1, c>=K-1, (r-K+1)%K_stride==0 and (c-K+1)%K_stride==0.
- Conv result: sum over i,j of w(i,j)*x(r-K+1+i, c-K+1+j).
  - Products are 32-bit signed; accumulation is 36-bit signed.
  - pxl_out is the low 16 bits of the sum (wrap, no saturation).
- Conv latency: pxl_out and o_data_valid are registered and appear one cycle after the completing pixel is accepted. o_data_valid is high for exactly that cycle; pxl_out holds its last value otherwise.
- count:
  - Clears to 0 when pixel (0,0) of a new frame is accepted.
  - Increments in the same cycle o_data_valid rises.
  - Reads W*H after the final output of a frame.
- Pooling input: consumes the conv stream only, in raster order over the WxH map, tracking its own conv-map row/col counters.
  - Stores P-1 rows of W conv values plus current-row partials.
- Pooling output: a window is complete when the conv value at map position (R,C) arrives with R>=P-1, C>=P-1, (R-P+1)%P_stride==0 and (C-P+1)%P_stride==0.
  - Output is the signed maximum of the PxP values.
  - Incomplete edge windows are dropped.
- Pooling latency: o_max_pooled_pixel and o_data_valid_pooling are registered one cycle after the o_data_valid that completes the window, i.e. two cycles after the completing input pixel. The valid is a one-cycle pulse.
- Per frame: exactly W*H conv pulses and PW*PH pool pulses. Pooling counters wrap with the conv frame.
- Simultaneous events: a frame-end pixel and new-frame pixels on consecutive cycles need no bubble.
- Reset mid-frame has priority over everything.

Test Plan:
- Reset, then kernel all +1 and a 6x6 image with x(r,c)=6r+c, one pixel per cycle.
  - Required: 16 conv pulses with values 54R+9C+63 (first 63, then 72, 81, 90, 117, ...).
  - The first pulse occurs one cycle after pixel index 14 is accepted.
  - count ends at 16.
  - Pooled outputs 126, 144, 234, 252, each two cycles after its completing pixel.
- Same image, kernel all -1 (0xFFFF): conv first output 0xFFC1 (-63); pooled outputs -63, -81, -171, -189.
- Same as the first scenario, but i_data_valid deasserted for 3 cycles after pixel 8 and for 1 cycle after pixel 20: identical value sequences, with pulses shifted by the gap lengths.
- Two back-to-back frames with no gap: count reaches 16, clears at the second frame's pixel (0,0), and the second frame reproduces the first frame's outputs exactly.
- reset pulsed low for one cycle after pixel 17, then a full fresh frame:
  - all outputs 0 during reset;
  - no pulses from the aborted frame;
  - the fresh frame's outputs match the first scenario.
- Overflow: all pixels 0x7FFF, kernel all +1: conv sum 9*32767=294903, so pxl_out=0x7FF7 (low 16 bits) and pooled output=0x7FF7.
